// File: rtl/dds_spi_pkg.sv
// Shared definitions for the AD9957 FTW loader: state encoding, frame
// geometry and the instruction/data frame builder.
package dds_spi_pkg;

  // One instruction byte plus the 64-bit single-tone profile word.
  localparam int unsigned FRAME_BITS = 72;

  // AD9957 instruction byte: bit 7 low selects a write.
  localparam logic AD9957_WRITE = 1'b0;

  // Single-tone profile 0 register address.
  localparam logic [4:0] PROFILE0_ADDR = 5'h0E;

  // Width of the phase/delay counters (covers any practical divider).
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_IOUPD,
    ST_GAP
  } state_t;

  // Instruction byte followed by {2'b00, ASF, POW, FTW}, MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [4:0]  addr,
    input logic [13:0] asf,
    input logic [15:0] pow,
    input logic [31:0] ftw
  );
    return {AD9957_WRITE, 2'b00, addr, 2'b00, asf, pow, ftw};
  endfunction

endpackage

// File: rtl/dds_spi_shift.sv
// SPI mode-0 serializer: SCLK divider, 72-bit shift register and bit
// counter. A start pulse loads the frame; last_bit flags the final cycle
// of the last high phase so the parent can leave its SHIFT state.
module dds_spi_shift
  import dds_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sclk,
  output logic                  sdio,
  output logic                  last_bit
);

  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  logic [CNT_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  active;
  logic                  div_last;
  logic                  final_bit;

  assign div_last  = (div_cnt == CNT_W'(CLK_DIV - 1));
  assign final_bit = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign last_bit  = active && sclk && div_last && final_bit;

  // Divider and shifter: sdio changes only when a new low phase begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      sdio    <= 1'b0;
    end else if (start) begin
      shreg   <= {frame[FRAME_BITS-2:0], 1'b0};
      sdio    <= frame[FRAME_BITS-1];
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (div_last) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (final_bit) begin
            active <= 1'b0;
            sdio   <= 1'b0;
          end else begin
            sdio    <= shreg[FRAME_BITS-1];
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dds_ftw_spi_loader.sv
// Frequency-hop FTW loader: captures freq_factor on a freq_en rising
// edge, writes it to the AD9957 profile register over 3-wire SPI, then
// pulses IO_UPDATE. A one-deep pending slot absorbs hops during a transfer.
module dds_ftw_spi_loader
  import dds_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned IOUPD_CYCLES = 4,
  parameter logic [4:0]  PROFILE_ADDR = PROFILE0_ADDR,
  parameter logic [13:0] ASF          = 14'h3FFF,
  parameter logic [15:0] POW          = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] freq_factor,
  input  logic        freq_en,
  output logic        dds_cs_n,
  output logic        dds_sclk,
  output logic        dds_sdio,
  output logic        dds_io_update,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             freq_en_d;
  logic             rise;
  logic             launch;
  logic [31:0]      launch_word;
  logic [31:0]      cur_word;
  logic             pend_valid;
  logic [31:0]      pend_word;
  logic             shift_start;
  logic             shift_last;

  logic             cs_n_next;
  logic             io_update_next;
  logic             busy_next;
  logic             done_next;
  logic             overrun_next;

  assign rise        = freq_en & ~freq_en_d;
  // A fresh edge in IDLE wins over a stale pending word.
  assign launch      = (state == ST_IDLE) && (rise || pend_valid);
  assign launch_word = rise ? freq_factor : pend_word;
  assign shift_start = (state == ST_CS_SETUP) && cnt_last;

  // Terminal count for the timed states.
  always_comb begin
    cnt_last = 1'b0;
    unique case (state)
      ST_CS_SETUP, ST_CS_HOLD, ST_GAP: cnt_last = (cnt == CNT_W'(CLK_DIV - 1));
      ST_IOUPD:                        cnt_last = (cnt == CNT_W'(IOUPD_CYCLES - 1));
      default:                         cnt_last = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (launch)     state_next = ST_CS_SETUP;
      ST_CS_SETUP: if (cnt_last)   state_next = ST_SHIFT;
      ST_SHIFT:    if (shift_last) state_next = ST_CS_HOLD;
      ST_CS_HOLD:  if (cnt_last)   state_next = ST_IOUPD;
      ST_IOUPD:    if (cnt_last)   state_next = ST_GAP;
      ST_GAP:      if (cnt_last)   state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  // aligned with the state it belongs to.
  always_comb begin
    cs_n_next      = !(state_next inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
    io_update_next = (state_next == ST_IOUPD);
    busy_next      = (state_next != ST_IDLE);
    done_next      = (state == ST_GAP) && cnt_last;
    // Any edge that finds the slot full (idle or busy) drops a word.
    overrun_next   = rise && pend_valid;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dds_cs_n      <= 1'b1;
      dds_io_update <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      dds_cs_n      <= cs_n_next;
      dds_io_update <= io_update_next;
      busy          <= busy_next;
      done          <= done_next;
      overrun       <= overrun_next;
    end
  end

  // Edge history, phase counter, current word and pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_en_d  <= 1'b1;
      cnt        <= '0;
      cur_word   <= '0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
    end else begin
      freq_en_d <= freq_en;
      if ((state_next != state) || (state == ST_IDLE) || (state == ST_SHIFT)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (launch) begin
        cur_word <= launch_word;
      end
      if (state == ST_IDLE) begin
        pend_valid <= 1'b0;
      end else if (rise) begin
        pend_valid <= 1'b1;
        pend_word  <= freq_factor;
      end
    end
  end

  dds_spi_shift #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .start    (shift_start),
    .frame    (build_frame(PROFILE_ADDR, ASF, POW, cur_word)),
    .sclk     (dds_sclk),
    .sdio     (dds_sdio),
    .last_bit (shift_last)
  );

endmodule

// File: tb/tb_dds_ftw_spi_loader.sv
// Directed bench for dds_ftw_spi_loader: a default-parameter instance and
// a CLK_DIV=1/IOUPD_CYCLES=1 instance, with a frame scoreboard fed by the
// stimulus and drained by an SPI monitor.
module tb_dds_ftw_spi_loader;

  logic        clk;
  logic        rst_a, en_a, cs_a, sclk_a, sdio_a, iou_a, busy_a, done_a, ovr_a;
  logic [31:0] ff_a;
  logic        rst_b, en_b, cs_b, sclk_b, sdio_b, iou_b, busy_b, done_b, ovr_b;
  logic [31:0] ff_b;

  int checks = 0;
  int errors = 0;

  logic [71:0] q_a[$];
  logic [71:0] q_b[$];

  dds_ftw_spi_loader u_dut_a (
    .clk(clk), .rst(rst_a), .freq_factor(ff_a), .freq_en(en_a),
    .dds_cs_n(cs_a), .dds_sclk(sclk_a), .dds_sdio(sdio_a),
    .dds_io_update(iou_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  dds_ftw_spi_loader #(.CLK_DIV(1), .IOUPD_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .freq_factor(ff_b), .freq_en(en_b),
    .dds_cs_n(cs_b), .dds_sclk(sclk_b), .dds_sdio(sdio_b),
    .dds_io_update(iou_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_frame(input logic [31:0] w);
    return {8'h0E, 16'h3FFF, 16'h0000, w};
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int iou_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // SPI monitor state, index 0 = default instance, 1 = fast instance
  logic [1:0]  m_rst, m_cs, m_sclk, m_sdio, m_iou, m_ovr;
  logic [1:0]  p_cs, p_sclk, p_iou;
  logic [71:0] cap[2];
  int          nbits[2], cyc[2], iou_w[2], io_pulses[2], ovr_cnt[2];
  bit          per_bad[2];

  assign m_rst  = {rst_b, rst_a};
  assign m_cs   = {cs_b, cs_a};
  assign m_sclk = {sclk_b, sclk_a};
  assign m_sdio = {sdio_b, sdio_a};
  assign m_iou  = {iou_b, iou_a};
  assign m_ovr  = {ovr_b, ovr_a};

  initial begin
    p_cs = '1; p_sclk = '0; p_iou = '0;
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0; nbits[i] = 0; cyc[i] = 0; iou_w[i] = 0;
      io_pulses[i] = 0; ovr_cnt[i] = 0; per_bad[i] = 1'b0;
    end
  end

  // Capture bits on SCLK rise, score frames on CS_N rise, time IO_UPDATE.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [71:0] expv;
      int          have;
      if (m_ovr[i]) ovr_cnt[i]++;
      if (m_rst[i]) begin
        nbits[i] = 0; cyc[i] = 0; iou_w[i] = 0; per_bad[i] = 1'b0;
      end else begin
        cyc[i]++;
        if (m_sclk[i] && !p_sclk[i] && !m_cs[i]) begin
          if (nbits[i] != 0 && cyc[i] != 2 * div_of(i)) per_bad[i] = 1'b1;
          cyc[i] = 0;
          cap[i] = {cap[i][70:0], m_sdio[i]};
          nbits[i]++;
        end
        if (m_cs[i] && !p_cs[i]) begin
          have = (i == 0) ? q_a.size() : q_b.size();
          check("frame_expected", have != 0, 1);
          if (have != 0) begin
            expv = (i == 0) ? q_a.pop_front() : q_b.pop_front();
            check("frame_bits", nbits[i], 72);
            check("frame_data", cap[i], expv);
            check("sclk_period", per_bad[i], 0);
          end
          nbits[i] = 0; per_bad[i] = 1'b0;
        end
        if (m_iou[i]) iou_w[i]++;
        if (!m_iou[i] && p_iou[i]) begin
          check("ioupd_width", iou_w[i], iou_of(i));
          io_pulses[i]++;
          iou_w[i] = 0;
        end
      end
      p_cs[i] = m_cs[i]; p_sclk[i] = m_sclk[i]; p_iou[i] = m_iou[i];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Steps until done of the chosen instance, dropping its freq_en at step
  // rel (0 = leave alone). k = steps taken, -1 if the budget ran out.
  task automatic wait_done(input int which, input int rel, output int k);
    k = -1;
    for (int c = 1; c <= 3000; c++) begin
      step(1);
      if (c == rel) begin
        if (which == 0) en_a = 1'b0; else en_b = 1'b0;
      end
      if ((which == 0) ? done_a : done_b) begin
        k = c;
        return;
      end
    end
  endtask

  initial begin
    int k, bad, ovr0, iop, reached;
    rst_a = 1'b1; en_a = 1'b0; ff_a = '0;
    rst_b = 1'b1; en_b = 1'b0; ff_b = '0;
    step(3);
    check("rst_cs_n", cs_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_sdio", sdio_a, 0);
    check("rst_ioupd", iou_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_overrun", ovr_a, 0);
    rst_a = 1'b0;
    step(2);

    // single hop, freq_en held 12 cycles
    ff_a = 32'h1999999A; en_a = 1'b1; q_a.push_back(exp_frame(32'h1999999A));
    step(1);
    check("hop_cs_low", cs_a, 0);
    check("hop_busy", busy_a, 1);
    wait_done(0, 11, k);
    check("hop_done_time", 1 + k, 593);
    check("hop_busy_clear", busy_a, 0);
    step(1);
    check("hop_done_pulse", done_a, 0);
    check("hop_io_pulses", io_pulses[0], 1);

    // level held high across reset release
    rst_a = 1'b1; en_a = 1'b1;
    step(3);
    rst_a = 1'b0;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      step(1);
      if (!cs_a || busy_a) bad++;
    end
    check("level_quiet", bad, 0);
    en_a = 1'b0;
    step(2);

    // overrun: A, B, C during one transfer
    ovr0 = ovr_cnt[0];
    ff_a = 32'hAAAA0001; en_a = 1'b1; q_a.push_back(exp_frame(32'hAAAA0001));
    step(2); en_a = 1'b0; step(50);
    ff_a = 32'hBBBB0002; en_a = 1'b1;
    step(2); en_a = 1'b0; step(50);
    check("ovr_none_yet", ovr_cnt[0] - ovr0, 0);
    ff_a = 32'hCCCC0003; en_a = 1'b1; q_a.push_back(exp_frame(32'hCCCC0003));
    step(1);
    check("ovr_pulse", ovr_a, 1);
    en_a = 1'b0;
    step(1);
    check("ovr_one_cycle", ovr_a, 0);
    wait_done(0, 0, k);
    check("ovr_done_a", k, 487);
    wait_done(0, 0, k);
    check("ovr_done_c", k, 593);
    check("ovr_count", ovr_cnt[0] - ovr0, 1);
    step(3);

    // reset at bit 30
    ff_a = 32'hDEAD0004; en_a = 1'b1;
    step(2); en_a = 1'b0;
    reached = 0;
    for (int c = 0; c < 2000; c++) begin
      if (nbits[0] >= 30) begin reached = 1; break; end
      step(1);
    end
    check("mid_reached", reached, 1);
    iop = io_pulses[0];
    rst_a = 1'b1;
    step(1);
    check("mid_cs_n", cs_a, 1);
    check("mid_sclk", sclk_a, 0);
    check("mid_sdio", sdio_a, 0);
    check("mid_ioupd", iou_a, 0);
    check("mid_busy", busy_a, 0);
    step(1);
    rst_a = 1'b0;
    step(2);
    check("mid_no_ioupd", io_pulses[0] - iop, 0);
    ff_a = 32'h0E0E0005; en_a = 1'b1; q_a.push_back(exp_frame(32'h0E0E0005));
    wait_done(0, 2, k);
    check("mid_clean_done", k, 593);
    step(3);

    // edge in the final GAP cycle
    ff_a = 32'h12345678; en_a = 1'b1; q_a.push_back(exp_frame(32'h12345678));
    for (int c = 1; c <= 592; c++) begin
      step(1);
      if (c == 2) en_a = 1'b0;
    end
    check("gap_busy_last", busy_a, 1);
    ff_a = 32'h87654321; en_a = 1'b1; q_a.push_back(exp_frame(32'h87654321));
    step(1);
    check("gap_done", done_a, 1);
    check("gap_cs_idle", cs_a, 1);
    step(1);
    check("gap_cs_low", cs_a, 0);
    en_a = 1'b0;
    wait_done(0, 0, k);
    check("gap_second_done", k, 592);
    step(3);

    // fast instance: CLK_DIV=1, IOUPD_CYCLES=1
    check("b_rst_cs_n", cs_b, 1);
    rst_b = 1'b0;
    step(2);
    ff_b = 32'hCAFEF00D; en_b = 1'b1; q_b.push_back(exp_frame(32'hCAFEF00D));
    wait_done(1, 3, k);
    check("b_done_time", k, 149);
    step(2);
    ff_b = 32'h80000001; en_b = 1'b1; q_b.push_back(exp_frame(32'h80000001));
    wait_done(1, 1, k);
    check("b_done_time2", k, 149);
    step(3);

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
